uart_rx_oversampled: RTL and testbench
======================================

// Module: uart_rx_oversampled
// PURPOSE
//  UART serial receiver with a built-in baud-tick generator. Recovers 8N1 frames
//  (LSB first) from an asynchronous serial line using 16x oversampling, then
//  presents each byte with a one-cycle done strobe. Sits between the board RX pin
//  and the byte-consuming logic (e.g. ALU/interface FSM).
// PARAMETERS
//  CLK_FREQ    5_000_000  system clock frequency, Hz (200 ns period)
//  BAUD_RATE   9600       serial bit rate; one bit = 104_167 ns
//  OVERSAMPLE  16         ticks per bit
//  DATA_BITS   8          data bits per frame
//  DIVISOR     CLK_FREQ/(BAUD_RATE*OVERSAMPLE) = 32 (integer div), clocks per tick
// PORTS
//  i_clock          in   1          system clock, rising edge
//  i_reset          in   1          asynchronous, active-low reset
//  i_rx_data_input  in   1          serial line, idle high, async to i_clock
//  o_tick           out  1          baud tick, 1-cycle pulse every DIVISOR clocks
//  o_done_bit       out  1          1-cycle strobe: valid frame received
//  o_frame_err      out  1          1-cycle strobe: stop bit sampled low
//  o_data_byte      out  DATA_BITS  last received byte, held until next frame end
// BEHAVIOUR
//  Reset (i_reset=0, async): tick counter=0, FSM=IDLE, shift reg=0, bit/tick
//   counters=0, o_tick=0, o_done_bit=0, o_frame_err=0, o_data_byte=0; sync flops=1.
//  Tick gen: free-running counter 0..DIVISOR-1; o_tick=1 for the cycle the counter
//   is DIVISOR-1, counter then wraps to 0. Runs regardless of FSM state.
//  Input: 2-flop synchronizer (reset value 1); FSM uses synced value only
//   (2-cycle input latency).
//  FSM (all counting on o_tick only):
//   IDLE: synced rx=0 -> START, tick_cnt=0.
//   START: count ticks; at tick_cnt=7 (mid start bit): rx=0 -> DATA, tick_cnt=0,
//    bit_cnt=0; rx=1 -> IDLE (glitch rejected, no strobe).
//   DATA: at tick_cnt=15 sample rx, shift into MSB of shift reg (LSB-first line
//    order), tick_cnt=0, bit_cnt++; after bit DATA_BITS-1 -> STOP.
//   STOP: at tick_cnt=15 sample rx; o_data_byte<=shift reg in both cases;
//    rx=1 -> o_done_bit=1 one cycle, -> IDLE;
//    rx=0 -> o_frame_err=1 one cycle, -> WAIT_IDLE.
//   WAIT_IDLE: stay until synced rx=1, then -> IDLE (no false start on a held-low
//    line/break).
//  o_done_bit and o_frame_err never assert together; each is exactly one i_clock
//   wide. o_data_byte changes only in the same cycle one of them asserts.
//  Reset mid-frame: abort immediately, no strobe, o_data_byte=0; next falling edge
//   after release starts a fresh frame.
//  Counters sized for OVERSAMPLE and DATA_BITS; no wrap issues within one frame.
//  Sampling point: ~8 ticks after detected falling edge, i.e. mid-bit; tolerates
//   +/-3% baud mismatch (DIVISOR rounding gives -1.7%).
// TESTING
//  Tick: after reset release, o_tick pulses every 32 clocks (6.4 us), width 1 clk.
//  Valid frame: idle 104 us, start, 0xAA LSB first, stop=1 -> o_done_bit one pulse
//   ~mid stop bit, o_data_byte=0xAA, o_frame_err=0.
//  Bad stop: start, bits 0,1,0,1,0,1,0,1 then 0 in stop slot, line high after ->
//   o_frame_err pulse, o_data_byte=0xAA, no o_done_bit; next frame 0x3C received
//   OK.
//  Glitch: line low 20 us then high -> no strobes, FSM back to IDLE, o_data_byte
//   unchanged.
//  Back-to-back: 0x55 then 0xFF with single stop bit between -> two o_done_bit
//   pulses, values 0x55 then 0xFF.
//  Reset mid-frame: drop i_reset during bit 3 of 0x81 -> outputs 0, no strobe;
//   after release, following 0x81 frame received correctly.

Source files
------------

// File: rtl/uart_rx_oversampled.sv
// rtl/uart_rx_oversampled.sv - 8N1 UART receiver with 16x oversampling and built-in baud tick generator
module uart_rx_oversampled #(
    parameter int CLK_FREQ   = 5_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_rx_data_input,
    output logic                 o_tick,
    output logic                 o_done_bit,
    output logic                 o_frame_err,
    output logic [DATA_BITS-1:0] o_data_byte
);

    localparam int DIVISOR = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV_W   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam int OS_W    = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BIT_W   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIVISOR - 1);
    // Start bit is checked at its middle; data/stop bits one full bit later each.
    localparam logic [OS_W-1:0]  MID_TICK  = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  LAST_TICK = OS_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_IDLE = 3'd4
    } state_t;

    logic [DIV_W-1:0]     r_div_cnt;
    logic                 w_tick;
    logic                 r_rx_meta;
    logic                 r_rx_sync;
    state_t               r_state;
    logic [OS_W-1:0]      r_tick_cnt;
    logic [BIT_W-1:0]     r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data_byte;
    logic                 r_done;
    logic                 r_frame_err;

    assign w_tick      = (r_div_cnt == DIV_LAST);
    assign o_tick      = w_tick;
    assign o_done_bit  = r_done;
    assign o_frame_err = r_frame_err;
    assign o_data_byte = r_data_byte;

    // Free-running baud tick divider, independent of receiver state.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_div_cnt <= '0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    // Two-flop synchronizer; resets to idle-high so release never looks like a start edge.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= i_rx_data_input;
            r_rx_sync <= r_rx_meta;
        end
    end

    // Receive FSM: all bit timing advances on baud ticks; strobes are single-cycle.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= S_IDLE;
            r_tick_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_data_byte <= '0;
            r_done      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!r_rx_sync) begin
                        r_state    <= S_START;
                        r_tick_cnt <= '0;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        if (r_tick_cnt == MID_TICK) begin
                            r_tick_cnt <= '0;
                            if (!r_rx_sync) begin
                                r_state   <= S_DATA;
                                r_bit_cnt <= '0;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        if (r_tick_cnt == LAST_TICK) begin
                            r_tick_cnt <= '0;
                            r_shift    <= {r_rx_sync, r_shift[DATA_BITS-1:1]};
                            if (r_bit_cnt == LAST_BIT) begin
                                r_state <= S_STOP;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end
                S_STOP: begin
                    if (w_tick) begin
                        if (r_tick_cnt == LAST_TICK) begin
                            r_tick_cnt  <= '0;
                            r_data_byte <= r_shift;
                            if (r_rx_sync) begin
                                r_done  <= 1'b1;
                                r_state <= S_IDLE;
                            end else begin
                                r_frame_err <= 1'b1;
                                r_state     <= S_WAIT_IDLE;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end
                S_WAIT_IDLE: begin
                    // A held-low line (break) must return high before a new start is accepted.
                    if (r_rx_sync) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// tb/tb_uart_rx_oversampled.sv - scoreboard bench for uart_rx_oversampled
`timescale 1ns/1ps
module tb_uart_rx_oversampled;

    localparam int BIT_NS = 104167;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       tick;
    logic       done;
    logic       ferr;
    logic [7:0] data;

    int checks = 0;
    int errors = 0;

    logic [8:0] exp_q[$];
    logic [8:0] obs_q[$];
    int         both_cnt = 0;
    int         wide_cnt = 0;
    int         stray_cnt = 0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_strobe = 1'b0;

    uart_rx_oversampled dut (
        .i_clock         (clk),
        .i_reset         (rst_n),
        .i_rx_data_input (rx),
        .o_tick          (tick),
        .o_done_bit      (done),
        .o_frame_err     (ferr),
        .o_data_byte     (data)
    );

    always #100 clk = ~clk;

    // Record every strobe as {frame_err, byte}; flag overlaps, wide pulses and stray byte changes.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_data   = data;
            prev_strobe = 1'b0;
        end else begin
            if (done && ferr) both_cnt++;
            if (done || ferr) begin
                obs_q.push_back({ferr, data});
                if (prev_strobe) wide_cnt++;
            end else if (data !== prev_data) begin
                stray_cnt++;
            end
            prev_strobe = done | ferr;
            prev_data   = data;
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic stop_v);
        rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            #(BIT_NS);
        end
        rx = stop_v;
        #(BIT_NS);
        rx = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b required 0", tick); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b required 0", done); end
        checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b required 0", ferr); end
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data got %h required 00", data); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_tick;
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick && n < 100);
        checks++; if (n !== 31) begin errors++; $display("FAIL tick_first got %0d clocks required 31", n); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (tick !== 1'b0) begin errors++; $display("FAIL tick_width got %b required 0", tick); end
            n = 1;
            do begin
                @(negedge clk);
                n++;
            end while (!tick && n < 100);
            checks++; if (n !== 32) begin errors++; $display("FAIL tick_period got %0d clocks required 32", n); end
        end
    endtask

    task automatic test_valid_frame;
        logic [8:0] e, o;
        #(BIT_NS);
        exp_q.push_back({1'b0, 8'hAA});
        send_byte(8'hAA, 1'b1);
        repeat (20) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL valid_frame missing event required %h", e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL valid_frame got %h required %h", o, e); end
            end
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL valid_frame extra events %0d required 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_bad_stop;
        logic [8:0] e, o;
        #(BIT_NS);
        exp_q.push_back({1'b1, 8'hAA});
        send_byte(8'hAA, 1'b0);
        #(BIT_NS);
        exp_q.push_back({1'b0, 8'h3C});
        send_byte(8'h3C, 1'b1);
        repeat (20) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL bad_stop missing event required %h", e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL bad_stop got %h required %h", o, e); end
            end
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL bad_stop extra events %0d required 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_glitch;
        logic [8:0] e, o;
        #(BIT_NS);
        rx = 1'b0;
        #20000;
        rx = 1'b1;
        #(2 * BIT_NS);
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL glitch strobes %0d required 0", obs_q.size()); obs_q.delete(); end
        checks++; if (data !== 8'h3C) begin errors++; $display("FAIL glitch_data got %h required 3c", data); end
        exp_q.push_back({1'b0, 8'h5A});
        send_byte(8'h5A, 1'b1);
        repeat (20) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL glitch_recover missing event required %h", e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL glitch_recover got %h required %h", o, e); end
            end
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL glitch_recover extra events %0d required 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_back_to_back;
        logic [8:0] e, o;
        #(BIT_NS);
        exp_q.push_back({1'b0, 8'h55});
        send_byte(8'h55, 1'b1);
        exp_q.push_back({1'b0, 8'hFF});
        send_byte(8'hFF, 1'b1);
        repeat (20) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL back_to_back missing event required %h", e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL back_to_back got %h required %h", o, e); end
            end
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL back_to_back extra events %0d required 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_reset_mid_frame;
        logic [8:0] e, o;
        int         strobes;
        #(BIT_NS);
        strobes = 0;
        fork
            send_byte(8'h81, 1'b1);
            begin
                #(4 * BIT_NS + BIT_NS / 2);
                rst_n = 1'b0;
                #1000;
                checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_mid_data got %h required 00", data); end
                for (int i = 0; i < 50; i++) begin
                    @(negedge clk);
                    if (done || ferr) strobes++;
                end
                checks++; if (strobes != 0) begin errors++; $display("FAIL reset_mid_strobe got %0d required 0", strobes); end
            end
        join
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        #(BIT_NS);
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL reset_mid_events %0d required 0", obs_q.size()); obs_q.delete(); end
        exp_q.push_back({1'b0, 8'h81});
        send_byte(8'h81, 1'b1);
        repeat (20) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL reset_mid_recover missing event required %h", e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL reset_mid_recover got %h required %h", o, e); end
            end
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL reset_mid_recover extra events %0d required 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_strobe_integrity;
        checks++; if (both_cnt != 0) begin errors++; $display("FAIL strobe_overlap got %0d required 0", both_cnt); end
        checks++; if (wide_cnt != 0) begin errors++; $display("FAIL strobe_width got %0d required 0", wide_cnt); end
        checks++; if (stray_cnt != 0) begin errors++; $display("FAIL data_stray_change got %0d required 0", stray_cnt); end
    endtask

    initial begin
        test_reset;
        test_tick;
        test_valid_frame;
        test_bad_stop;
        test_glitch;
        test_back_to_back;
        test_reset_mid_frame;
        test_strobe_integrity;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
